// File: rtl/keydec.sv
// keydec: debounced 4x4 keypad reader; decodes the pressed key and strobes once per press.
// Optional auto-repeat while a key is held is enabled by defining KEY_REPEAT_EN.
module keydec #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_DELAY    = 10000000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] kpc,
  input  logic [3:0] kpr,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

`ifdef KEY_REPEAT_EN
  localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_P = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
`else
  localparam int MAX_P = DEBOUNCE_CYCLES;
`endif
  localparam int CW = $clog2(MAX_P);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("keydec: DEBOUNCE_CYCLES must be >= 2 and repeat timings >= 1");
  end

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t        state, state_nx;
  logic [3:0]    kpr_m, kpr_s;
  logic [7:0]    sample;
  logic [7:0]    cap, cap_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0]    code_nx;
  logic          valid_nx, held_nx;
  logic          legal;

  function automatic logic one_cold(input logic [3:0] v);
    return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
  endfunction

  // Capture layout is {kpc, kpr}; bit 3 of each selects column 1 / row 1.
  function automatic logic [3:0] decode(input logic [7:0] s);
    logic [3:0] code;
    code = 4'h0;
    case (s)
      8'b0111_0111: code = 4'h1;
      8'b1011_0111: code = 4'h2;
      8'b1101_0111: code = 4'h3;
      8'b1110_0111: code = 4'hA;
      8'b0111_1011: code = 4'h4;
      8'b1011_1011: code = 4'h5;
      8'b1101_1011: code = 4'h6;
      8'b1110_1011: code = 4'hB;
      8'b0111_1101: code = 4'h7;
      8'b1011_1101: code = 4'h8;
      8'b1101_1101: code = 4'h9;
      8'b1110_1101: code = 4'hC;
      8'b0111_1110: code = 4'hE;
      8'b1011_1110: code = 4'h0;
      8'b1101_1110: code = 4'hF;
      8'b1110_1110: code = 4'hD;
      default:      code = 4'h0;
    endcase
    return code;
  endfunction

  assign sample = {kpc, kpr_s};
  assign legal  = one_cold(kpc) && one_cold(kpr_s);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kpr_m <= 4'hF;
      kpr_s <= 4'hF;
    end else begin
      kpr_m <= kpr;
      kpr_s <= kpr_m;
    end
  end

`ifdef KEY_REPEAT_EN
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);
  logic [CW-1:0] rpt_cnt, rpt_cnt_nx;
  logic          rpt_first, rpt_first_nx;

  // rpt_first selects the initial hold delay; afterwards the shorter period applies.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else begin
      rpt_cnt   <= rpt_cnt_nx;
      rpt_first <= rpt_first_nx;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cap       <= 8'hFF;
      cnt       <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nx;
      cap       <= cap_nx;
      cnt       <= cnt_nx;
      key_code  <= code_nx;
      key_valid <= valid_nx;
      key_held  <= held_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cap_nx   = cap;
    cnt_nx   = cnt;
    code_nx  = key_code;
    valid_nx = 1'b0;
    held_nx  = key_held;
`ifdef KEY_REPEAT_EN
    rpt_cnt_nx   = rpt_cnt;
    rpt_first_nx = rpt_first;
`endif
    case (state)
      IDLE: begin
        if (legal) begin
          cap_nx   = sample;
          cnt_nx   = '0;
          state_nx = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (sample != cap) begin
          state_nx = IDLE;
        end else if (cnt == DB_LAST) begin
          code_nx  = decode(cap);
          valid_nx = 1'b1;
          held_nx  = 1'b1;
          state_nx = PRESSED;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      // Only a full row release matters here; other row/column changes are ignored.
      PRESSED: begin
        if (kpr_s == 4'hF) begin
          cnt_nx   = '0;
          state_nx = RELEASE;
        end
`ifdef KEY_REPEAT_EN
        else if (rpt_cnt == (rpt_first ? RD_LAST : RP_LAST)) begin
          valid_nx     = 1'b1;
          rpt_cnt_nx   = '0;
          rpt_first_nx = 1'b0;
        end else begin
          rpt_cnt_nx = rpt_cnt + 1'b1;
        end
`endif
      end
      RELEASE: begin
        if (kpr_s != 4'hF) begin
          state_nx = PRESSED;
        end else if (cnt == DB_LAST) begin
          held_nx  = 1'b0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
`ifdef KEY_REPEAT_EN
    if (state_nx == IDLE) begin
      rpt_cnt_nx   = '0;
      rpt_first_nx = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_keydec.sv
// Bench for keydec: table-driven key sweep plus hand-written bounce, reset and repeat sequences.
// Expected strobes (cycle and code) are queued at stimulus time and matched by a negedge monitor.
`timescale 1ns/1ps
module tb_keydec;
  localparam int DC = 4;
  localparam int RD = 20;
  localparam int RP = 8;
  localparam int LAT = DC + 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] kpc;
  logic [3:0] kpr;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] last_code = 4'h0;

  typedef struct {
    int         cyc;
    logic [3:0] code;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    logic [3:0] kpc;
    logic [3:0] kpr;
    logic       strobe;
    logic [3:0] code;
  } vec_t;
  vec_t vecs[19];

  keydec #(.DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .kpc(kpc),
    .kpr(kpr),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Every strobe must match the oldest queued expectation in both cycle and code.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_strobe", 32'(key_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("strobe_cycle", cyc, mon_e.cyc);
        checkOutput("strobe_code", 32'(key_code), 32'(mon_e.code));
      end
    end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
      mon_e = sb.pop_front();
      checkOutput("missed_strobe", 32'(key_valid), 32'd1);
    end
  end

  task automatic waitTo(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic pushExp(input int at, input logic [3:0] code);
    exp_t e;
    e.cyc  = at;
    e.code = code;
    sb.push_back(e);
    last_code = code;
  endtask

  task automatic applyStimulus(input logic [3:0] c, input logic [3:0] r,
                               input logic expect_strobe, input logic [3:0] code);
    kpc = c;
    kpr = r;
    if (expect_strobe) pushExp(cyc + LAT, code);
  endtask

  task automatic releaseKey(input string name);
    int t1;
    t1 = cyc;
    kpr = 4'hF;
    waitTo(t1 + LAT - 1);
    checkOutput({name, "_held_pre_release"}, 32'(key_held), 32'd1);
    waitTo(t1 + LAT);
    checkOutput({name, "_held_released"}, 32'(key_held), 32'd0);
    waitTo(t1 + LAT + 3);
  endtask

  task automatic pressRelease(input string name, input logic [3:0] c, input logic [3:0] r,
                              input logic [3:0] code, input int hold);
    int t0;
    t0 = cyc;
    applyStimulus(c, r, 1'b1, code);
    waitTo(t0 + LAT - 1);
    checkOutput({name, "_held_early"}, 32'(key_held), 32'd0);
    waitTo(t0 + LAT);
    checkOutput({name, "_held"}, 32'(key_held), 32'd1);
    waitTo(t0 + hold);
    releaseKey(name);
  endtask

  initial begin
    int t0;
    vecs[0]  = '{4'b0111, 4'b0111, 1'b1, 4'h1};
    vecs[1]  = '{4'b1011, 4'b0111, 1'b1, 4'h2};
    vecs[2]  = '{4'b1101, 4'b0111, 1'b1, 4'h3};
    vecs[3]  = '{4'b1110, 4'b0111, 1'b1, 4'hA};
    vecs[4]  = '{4'b0111, 4'b1011, 1'b1, 4'h4};
    vecs[5]  = '{4'b1011, 4'b1011, 1'b1, 4'h5};
    vecs[6]  = '{4'b1101, 4'b1011, 1'b1, 4'h6};
    vecs[7]  = '{4'b1110, 4'b1011, 1'b1, 4'hB};
    vecs[8]  = '{4'b0111, 4'b1101, 1'b1, 4'h7};
    vecs[9]  = '{4'b1011, 4'b1101, 1'b1, 4'h8};
    vecs[10] = '{4'b1101, 4'b1101, 1'b1, 4'h9};
    vecs[11] = '{4'b1110, 4'b1101, 1'b1, 4'hC};
    vecs[12] = '{4'b0111, 4'b1110, 1'b1, 4'hE};
    vecs[13] = '{4'b1011, 4'b1110, 1'b1, 4'h0};
    vecs[14] = '{4'b1101, 4'b1110, 1'b1, 4'hF};
    vecs[15] = '{4'b1110, 4'b1110, 1'b1, 4'hD};
    vecs[16] = '{4'b0111, 4'b0011, 1'b0, 4'h0};
    vecs[17] = '{4'b0011, 4'b0111, 1'b0, 4'h0};
    vecs[18] = '{4'b1111, 4'b0111, 1'b0, 4'h0};

    reset_n = 1'b0;
    kpc = 4'hF;
    kpr = 4'h0;
    waitTo(3);
    checkOutput("reset_valid", 32'(key_valid), 32'd0);
    checkOutput("reset_held", 32'(key_held), 32'd0);
    checkOutput("reset_code", 32'(key_code), 32'd0);

    // Key already down while reset releases: full debounce still required.
    t0 = cyc;
    applyStimulus(4'b1011, 4'b1101, 1'b1, 4'h8);
    reset_n = 1'b1;
    waitTo(t0 + LAT - 1);
    checkOutput("rst_rel_held_early", 32'(key_held), 32'd0);
    waitTo(t0 + LAT);
    checkOutput("rst_rel_held", 32'(key_held), 32'd1);
    waitTo(t0 + 10);
    releaseKey("rst_rel");

    pressRelease("clean8", 4'b1011, 4'b1101, 4'h8, 10);

    for (int i = 0; i < 19; i++) begin
      if (vecs[i].strobe) begin
        pressRelease("map", vecs[i].kpc, vecs[i].kpr, vecs[i].code, 10);
      end else begin
        t0 = cyc;
        applyStimulus(vecs[i].kpc, vecs[i].kpr, 1'b0, 4'h0);
        waitTo(t0 + 12);
        checkOutput("illegal_held", 32'(key_held), 32'd0);
        checkOutput("illegal_code", 32'(key_code), 32'(last_code));
        kpc = 4'hF;
        kpr = 4'hF;
        waitTo(t0 + 16);
      end
    end

    // Press bounce: 2-clock pulses never survive debounce; only the final hold strobes.
    t0 = cyc;
    kpc = 4'b0111;
    for (int k = 0; k < 4; k++) begin
      kpr = (k % 2 == 0) ? 4'b0111 : 4'hF;
      waitTo(t0 + 2 * (k + 1));
    end
    applyStimulus(4'b0111, 4'b0111, 1'b1, 4'h1);
    waitTo(cyc + LAT + 2);
    t0 = cyc;
    kpr = 4'hF;
    waitTo(t0 + 2);
    kpr = 4'b0111;
    waitTo(t0 + 12);
    checkOutput("glitch_held", 32'(key_held), 32'd1);
    releaseKey("glitch");

    // A second key while one is held is ignored.
    t0 = cyc;
    applyStimulus(4'b1011, 4'b1011, 1'b1, 4'h5);
    waitTo(t0 + 10);
    kpr = 4'b0111;
    waitTo(t0 + 22);
    checkOutput("second_key_code", 32'(key_code), 32'h5);
    checkOutput("second_key_held", 32'(key_held), 32'd1);
    releaseKey("second_key");

    // Reset while a key is held, then release reset with the key still down.
    t0 = cyc;
    applyStimulus(4'b1011, 4'b1011, 1'b1, 4'h5);
    waitTo(t0 + 10);
    reset_n = 1'b0;
    #1;
    checkOutput("midhold_rst_held", 32'(key_held), 32'd0);
    checkOutput("midhold_rst_code", 32'(key_code), 32'd0);
    last_code = 4'h0;
    waitTo(cyc + 2);
    t0 = cyc;
    pushExp(t0 + LAT, 4'h5);
    reset_n = 1'b1;
    waitTo(t0 + LAT - 1);
    checkOutput("post_rst_held_early", 32'(key_held), 32'd0);
    waitTo(t0 + 10);
    releaseKey("post_rst");

    // Hold '#' for 60 clocks; repeats only when the feature is built in.
    t0 = cyc;
    applyStimulus(4'b1101, 4'b1110, 1'b1, 4'hF);
`ifdef KEY_REPEAT_EN
    for (int e = t0 + LAT + RD; e <= t0 + 62; e += RP) pushExp(e, 4'hF);
`endif
    waitTo(t0 + 60);
    checkOutput("hold_code", 32'(key_code), 32'hF);
    releaseKey("hold");

    waitTo(cyc + 10);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
